core_ldst_misc_exec: RTL

- Execution side of the halfword/signed-byte load/store path (LDRH, STRH, LDRSB, LDRSH). Consumes the already-decoded misc ldst fields plus resolved operand values.
- Computes the effective address and issues one word-aligned data-bus transaction with byte enables. Lane-extracts and sign/zero-extends load data.
- Produces the Rd write (loads) and the Rn base writeback. Sits between the decode/issue stage and the data bus port.

---
 rtl/core_ldst_misc_exec.sv | 134 +++++++++++++
 1 files changed

// File: rtl/core_ldst_misc_exec.sv
// Execution unit for LDRH/STRH/LDRSB/LDRSH. It forms the effective address, issues one
// word-aligned bus transaction with byte lanes, and returns the Rd and Rn register writes.
module core_ldst_misc_exec (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  input  logic        load,
  input  logic        size_half,
  input  logic        sign_extend,
  input  logic        increment,
  input  logic        pre_indexed,
  input  logic        writeback,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [31:0] rn_value,
  input  logic [31:0] rd_value,
  input  logic [31:0] offset,
  output logic        bus_start,
  output logic        bus_write,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_data_wr,
  input  logic [31:0] bus_data_rd,
  input  logic        bus_ready,
  output logic        rd_wr_en,
  output logic [3:0]  rd_wr_num,
  output logic [31:0] rd_wr_value,
  output logic        rn_wr_en,
  output logic [3:0]  rn_wr_num,
  output logic [31:0] rn_wr_value,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;
  state_t state, state_nx;

  logic [31:0] sum_c, ea_c;
  logic        misalign_c;

  logic        load_q, half_q, sext_q, base_upd_q, fault_q;
  logic [3:0]  rn_q, rd_q;
  logic [31:0] rd_value_q, ea_q, sum_q, data_q;

  assign sum_c      = increment ? (rn_value + offset) : (rn_value - offset);
  assign ea_c       = pre_indexed ? sum_c : rn_value;
  assign misalign_c = size_half & ea_c[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_q     <= 1'b0;
      half_q     <= 1'b0;
      sext_q     <= 1'b0;
      base_upd_q <= 1'b0;
      fault_q    <= 1'b0;
      rn_q       <= 4'd0;
      rd_q       <= 4'd0;
      rd_value_q <= 32'd0;
      ea_q       <= 32'd0;
      sum_q      <= 32'd0;
      data_q     <= 32'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        load_q     <= load;
        half_q     <= size_half;
        sext_q     <= sign_extend;
        base_upd_q <= writeback | ~pre_indexed;
        fault_q    <= misalign_c;
        rn_q       <= rn;
        rd_q       <= rd;
        rd_value_q <= rd_value;
        ea_q       <= ea_c;
        sum_q      <= sum_c;
      end
      if ((state == ISSUE || state == WAIT) && bus_ready) data_q <= bus_data_rd;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = misalign_c ? FINISH : ISSUE;
      ISSUE:   state_nx = bus_ready ? FINISH : WAIT;
      WAIT:    if (bus_ready) state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane selection for loads, using the low address bits captured at start.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_value;

  always_comb begin
    byte_sel = data_q[7:0];
    case (ea_q[1:0])
      2'd1:    byte_sel = data_q[15:8];
      2'd2:    byte_sel = data_q[23:16];
      2'd3:    byte_sel = data_q[31:24];
      default: byte_sel = data_q[7:0];
    endcase
    half_sel = ea_q[1] ? data_q[31:16] : data_q[15:0];
    if (half_q) ld_value = {{16{sext_q & half_sel[15]}}, half_sel};
    else        ld_value = {{24{sext_q & byte_sel[7]}}, byte_sel};
  end

  logic on_bus, fin;
  assign on_bus = (state == ISSUE) || (state == WAIT);
  assign fin    = (state == FINISH);

  assign ready       = (state == IDLE);
  assign bus_start   = (state == ISSUE);
  assign bus_write   = on_bus & ~load_q;
  assign bus_addr    = on_bus ? ea_q[31:2] : 30'd0;
  assign bus_byteen  = ~on_bus ? 4'b0000 :
                       half_q ? (ea_q[1] ? 4'b1100 : 4'b0011) : (4'b0001 << ea_q[1:0]);
  assign bus_data_wr = (on_bus & ~load_q) ?
                       (half_q ? {2{rd_value_q[15:0]}} : {4{rd_value_q[7:0]}}) : 32'd0;

  // The loaded value takes priority over the base update when both target one register.
  assign done        = fin;
  assign fault       = fin & fault_q;
  assign rd_wr_en    = fin & ~fault_q & load_q;
  assign rd_wr_num   = rd_wr_en ? rd_q : 4'd0;
  assign rd_wr_value = rd_wr_en ? ld_value : 32'd0;
  assign rn_wr_en    = fin & ~fault_q & base_upd_q & ~(load_q && rn_q == rd_q);
  assign rn_wr_num   = rn_wr_en ? rn_q : 4'd0;
  assign rn_wr_value = rn_wr_en ? sum_q : 32'd0;

endmodule
